// File: rtl/regfile_wb_sched.sv
// Y86-64 register file with a pending-write FIFO merging E/M write-backs into one array port.
// Reads bypass from pending entries the cycle after acceptance; in_ready drops when fewer than two FIFO slots are free.
module regfile_wb_sched #(
    parameter int         DEPTH = 4,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         weE,
    input  logic [3:0]                   dstE,
    input  logic [63:0]                  valE,
    input  logic                         weM,
    input  logic [3:0]                   dstM,
    input  logic [63:0]                  valM,
    output logic                         in_ready,
    input  logic [3:0]                   srcA,
    input  logic [3:0]                   srcB,
    output logic [63:0]                  valA,
    output logic [63:0]                  valB,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         cmt_valid,
    output logic [3:0]                   cmt_dst,
    output logic [63:0]                  cmt_val,
    input  logic [3:0]                   dbg_sel,
    output logic [63:0]                  dbg_data
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int NREG = 15;

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [63:0]     rf_q   [NREG];
    logic [63:0]     rf_d   [NREG];
    logic [3:0]      fdst_q [DEPTH];
    logic [3:0]      fdst_d [DEPTH];
    logic [63:0]     fval_q [DEPTH];
    logic [63:0]     fval_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cmt_valid_q, cmt_valid_d;
    logic [3:0]      cmt_dst_q, cmt_dst_d;
    logic [63:0]     cmt_val_q, cmt_val_d;

    logic            acc_e, acc_m, pop;
    logic [PW-1:0]   m_ptr;

    // Readiness comes only from registered occupancy so producers never see a we->ready loop.
    assign in_ready = (count_q <= CW'(DEPTH-2));
    assign acc_e    = in_ready && weE && (dstE != RNONE);
    assign acc_m    = in_ready && weM && (dstM != RNONE);
    assign pop      = (count_q != '0);
    assign m_ptr    = wr_ptr_q + PW'(acc_e);

    always_comb begin
        fdst_d      = fdst_q;
        fval_d      = fval_q;
        rf_d        = rf_q;
        cmt_valid_d = pop;
        cmt_dst_d   = '0;
        cmt_val_d   = '0;
        if (acc_e) begin
            fdst_d[wr_ptr_q] = dstE;
            fval_d[wr_ptr_q] = valE;
        end
        // M is younger than E, so it lands after E and wins on a shared destination.
        if (acc_m) begin
            fdst_d[m_ptr] = dstM;
            fval_d[m_ptr] = valM;
        end
        if (pop) begin
            cmt_dst_d = fdst_q[rd_ptr_q];
            cmt_val_d = fval_q[rd_ptr_q];
            if (fdst_q[rd_ptr_q] != RNONE) begin
                rf_d[fdst_q[rd_ptr_q]] = fval_q[rd_ptr_q];
            end
        end
        wr_ptr_d = wr_ptr_q + PW'(acc_e) + PW'(acc_m);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(acc_e) + CW'(acc_m) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (acc_e || acc_m) state_d = S_DRAIN;
            S_DRAIN: if (count_d == '0)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= 64'(i);
            for (int i = 0; i < DEPTH; i++) begin
                fdst_q[i] <= '0;
                fval_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            cmt_valid_q <= 1'b0;
            cmt_dst_q   <= '0;
            cmt_val_q   <= '0;
        end else begin
            rf_q        <= rf_d;
            fdst_q      <= fdst_d;
            fval_q      <= fval_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_dst_q   <= cmt_dst_d;
            cmt_val_q   <= cmt_val_d;
        end
    end

    // Scans head to tail so the youngest matching pending entry overrides older ones.
    function automatic logic [63:0] read_port(input logic [3:0] src);
        logic [63:0]   r;
        logic [PW-1:0] idx;
        r   = '0;
        idx = '0;
        if (src != RNONE) begin
            r = rf_q[src];
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (fdst_q[idx] == src)) r = fval_q[idx];
            end
        end
        return r;
    endfunction

    assign valA      = read_port(srcA);
    assign valB      = read_port(srcB);
    assign dbg_data  = (dbg_sel == RNONE) ? 64'd0 : rf_q[dbg_sel];
    assign busy      = (state_q == S_DRAIN);
    assign count     = count_q;
    assign cmt_valid = cmt_valid_q;
    assign cmt_dst   = cmt_dst_q;
    assign cmt_val   = cmt_val_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, bypass, pair hazard, back-pressure, RNONE drop, reset mid-drain.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        weE, weM;
    logic [3:0]  dstE, dstM, srcA, srcB, dbg_sel;
    logic [63:0] valE, valM;
    logic        in_ready, busy, cmt_valid;
    logic [2:0]  count;
    logic [3:0]  cmt_dst;
    logic [63:0] valA, valB, cmt_val, dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_sched #(.DEPTH(4), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst),
        .weE(weE), .dstE(dstE), .valE(valE),
        .weM(weM), .dstM(dstM), .valM(valM),
        .in_ready(in_ready),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busy(busy), .count(count),
        .cmt_valid(cmt_valid), .cmt_dst(cmt_dst), .cmt_val(cmt_val),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        weE = 1'b0; dstE = 4'd0; valE = 64'd0;
        weM = 1'b0; dstM = 4'd0; valM = 64'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        srcA = 4'd3; srcB = 4'd14; dbg_sel = 4'd7;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (valA !== 64'd3) begin errors++; $display("FAIL reset_valA: got %h expected %h", valA, 64'd3); end
        checks++; if (valB !== 64'd14) begin errors++; $display("FAIL reset_valB: got %h expected %h", valB, 64'd14); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL reset_cmt_valid: got %b expected 0", cmt_valid); end
        checks++; if (cmt_dst !== 4'd0) begin errors++; $display("FAIL reset_cmt_dst: got %h expected 0", cmt_dst); end
        checks++; if (cmt_val !== 64'd0) begin errors++; $display("FAIL reset_cmt_val: got %h expected 0", cmt_val); end
        checks++; if (dbg_data !== 64'd7) begin errors++; $display("FAIL reset_dbg7: got %h expected %h", dbg_data, 64'd7); end
        srcA = 4'hF; dbg_sel = 4'hF;
        #1;
        checks++; if (valA !== 64'd0) begin errors++; $display("FAIL reset_valA_rnone: got %h expected 0", valA); end
        checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL reset_dbg_rnone: got %h expected 0", dbg_data); end
    endtask

    task automatic test_single_write;
        srcA = 4'd2; dbg_sel = 4'd2;
        weE = 1'b1; dstE = 4'd2; valE = 64'h55;
        #1;
        checks++; if (valA !== 64'd2) begin errors++; $display("FAIL single_no_same_cycle_bypass: got %h expected %h", valA, 64'd2); end
        tick();
        idle_inputs();
        checks++; if (valA !== 64'h55) begin errors++; $display("FAIL single_bypass: got %h expected %h", valA, 64'h55); end
        checks++; if (dbg_data !== 64'd2) begin errors++; $display("FAIL single_dbg_before: got %h expected %h", dbg_data, 64'd2); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL single_cmt_early: got %b expected 0", cmt_valid); end
        tick();
        checks++; if (cmt_valid !== 1'b1) begin errors++; $display("FAIL single_cmt_valid: got %b expected 1", cmt_valid); end
        checks++; if (cmt_dst !== 4'd2) begin errors++; $display("FAIL single_cmt_dst: got %h expected 2", cmt_dst); end
        checks++; if (cmt_val !== 64'h55) begin errors++; $display("FAIL single_cmt_val: got %h expected %h", cmt_val, 64'h55); end
        checks++; if (dbg_data !== 64'h55) begin errors++; $display("FAIL single_dbg_after: got %h expected %h", dbg_data, 64'h55); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        checks++; if (valA !== 64'h55) begin errors++; $display("FAIL single_valA_after: got %h expected %h", valA, 64'h55); end
        tick();
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL single_cmt_idle: got %b expected 0", cmt_valid); end
    endtask

    task automatic test_pair_hazard;
        srcA = 4'd4; dbg_sel = 4'd4;
        weE = 1'b1; dstE = 4'd4; valE = 64'h100;
        weM = 1'b1; dstM = 4'd4; valM = 64'h200;
        tick();
        idle_inputs();
        checks++; if (valA !== 64'h200) begin errors++; $display("FAIL pair_bypass_m: got %h expected %h", valA, 64'h200); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pair_count: got %0d expected 2", count); end
        checks++; if (dbg_data !== 64'd4) begin errors++; $display("FAIL pair_dbg0: got %h expected %h", dbg_data, 64'd4); end
        tick();
        checks++; if (cmt_valid !== 1'b1 || cmt_dst !== 4'd4 || cmt_val !== 64'h100) begin errors++; $display("FAIL pair_cmt1: got %b/%h/%h expected 1/4/%h", cmt_valid, cmt_dst, cmt_val, 64'h100); end
        checks++; if (valA !== 64'h200) begin errors++; $display("FAIL pair_bypass_mid: got %h expected %h", valA, 64'h200); end
        checks++; if (dbg_data !== 64'h100) begin errors++; $display("FAIL pair_dbg1: got %h expected %h", dbg_data, 64'h100); end
        tick();
        checks++; if (cmt_valid !== 1'b1 || cmt_dst !== 4'd4 || cmt_val !== 64'h200) begin errors++; $display("FAIL pair_cmt2: got %b/%h/%h expected 1/4/%h", cmt_valid, cmt_dst, cmt_val, 64'h200); end
        checks++; if (dbg_data !== 64'h200) begin errors++; $display("FAIL pair_dbg_final: got %h expected %h", dbg_data, 64'h200); end
        checks++; if (count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL pair_drained: got count %0d busy %b expected 0 0", count, busy); end
        tick();
    endtask

    task automatic test_back_pressure;
        int          exp_cnt [7] = '{2, 3, 2, 3, 2, 1, 0};
        int          exp_rdy [7] = '{1, 0, 1, 0, 1, 1, 1};
        logic [3:0]  exp_dst [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [63:0] exp_val [6] = '{64'hA0, 64'hA1, 64'hB5, 64'hB6, 64'hC8, 64'hC9};
        weE = 1'b1; dstE = 4'd0; valE = 64'hA0;
        weM = 1'b1; dstM = 4'd1; valM = 64'hA1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++; if (count !== 3'(exp_cnt[k])) begin errors++; $display("FAIL bp_count[%0d]: got %0d expected %0d", k, count, exp_cnt[k]); end
            checks++; if (in_ready !== 1'(exp_rdy[k])) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %0d", k, in_ready, exp_rdy[k]); end
            if (k >= 1) begin
                checks++;
                if (cmt_valid !== 1'b1 || cmt_dst !== exp_dst[k-1] || cmt_val !== exp_val[k-1]) begin
                    errors++;
                    $display("FAIL bp_commit[%0d]: got %b/%h/%h expected 1/%h/%h", k-1, cmt_valid, cmt_dst, cmt_val, exp_dst[k-1], exp_val[k-1]);
                end
            end
            case (k)
                0: begin dstE = 4'd5; valE = 64'hB5; dstM = 4'd6; valM = 64'hB6; end
                1: begin dstE = 4'd8; valE = 64'hC8; dstM = 4'd9; valM = 64'hC9; end
                3: idle_inputs();
                default: ;
            endcase
        end
        tick();
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL bp_cmt_idle: got %b expected 0", cmt_valid); end
        dbg_sel = 4'd9; srcB = 4'd5;
        #1;
        checks++; if (dbg_data !== 64'hC9) begin errors++; $display("FAIL bp_dbg9: got %h expected %h", dbg_data, 64'hC9); end
        checks++; if (valB !== 64'hB5) begin errors++; $display("FAIL bp_valB5: got %h expected %h", valB, 64'hB5); end
        dbg_sel = 4'd0;
        #1;
        checks++; if (dbg_data !== 64'hA0) begin errors++; $display("FAIL bp_dbg0: got %h expected %h", dbg_data, 64'hA0); end
    endtask

    task automatic test_rnone;
        srcA = 4'hF;
        weE = 1'b1; dstE = 4'hF; valE = 64'hDEAD;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rnone_count: got count %0d busy %b expected 0 0", count, busy); end
        checks++; if (valA !== 64'd0) begin errors++; $display("FAIL rnone_valA: got %h expected 0", valA); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnone_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL rnone_no_commit: got %b expected 0", cmt_valid); end
        srcA = 4'd3;
        weE = 1'b1; dstE = 4'd3; valE = 64'h33;
        weM = 1'b1; dstM = 4'hF; valM = 64'hDEAD;
        tick();
        idle_inputs();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rnone_m_dropped: got count %0d expected 1", count); end
        checks++; if (valA !== 64'h33) begin errors++; $display("FAIL rnone_bypass_e: got %h expected %h", valA, 64'h33); end
        tick();
        checks++; if (cmt_valid !== 1'b1 || cmt_dst !== 4'd3 || cmt_val !== 64'h33) begin errors++; $display("FAIL rnone_cmt_e: got %b/%h/%h expected 1/3/%h", cmt_valid, cmt_dst, cmt_val, 64'h33); end
        tick();
        checks++; if (cmt_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rnone_cmt_m: got valid %b count %0d expected 0 0", cmt_valid, count); end
    endtask

    task automatic test_reset_mid_drain;
        weE = 1'b1; dstE = 4'd10; valE = 64'h10;
        weM = 1'b1; dstM = 4'd1;  valM = 64'hA;
        tick();
        weE = 1'b1; dstE = 4'd2; valE = 64'hB;
        weM = 1'b1; dstM = 4'd3; valM = 64'hC;
        tick();
        idle_inputs();
        srcA = 4'd1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count_pre: got %0d expected 3", count); end
        checks++; if (cmt_valid !== 1'b1 || cmt_dst !== 4'd10) begin errors++; $display("FAIL mid_cmt_pre: got %b/%h expected 1/a", cmt_valid, cmt_dst); end
        #1;
        checks++; if (valA !== 64'hA) begin errors++; $display("FAIL mid_bypass_pre: got %h expected %h", valA, 64'hA); end
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_ready_busy: got %b %b expected 1 0", in_ready, busy); end
        checks++; if (cmt_valid !== 1'b0) begin errors++; $display("FAIL mid_cmt_valid: got %b expected 0", cmt_valid); end
        checks++; if (valA !== 64'd1) begin errors++; $display("FAIL mid_valA: got %h expected 1", valA); end
        dbg_sel = 4'd10;
        #1;
        checks++; if (dbg_data !== 64'd10) begin errors++; $display("FAIL mid_dbg10: got %h expected %h", dbg_data, 64'd10); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (cmt_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_no_commit[%0d]: got valid %b count %0d expected 0 0", k, cmt_valid, count); end
        end
        for (int r = 1; r <= 3; r++) begin
            dbg_sel = 4'(r);
            #1;
            checks++; if (dbg_data !== 64'(r)) begin errors++; $display("FAIL mid_array[%0d]: got %h expected %h", r, dbg_data, 64'(r)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        srcA = 4'd0; srcB = 4'd0; dbg_sel = 4'd0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_pair_hazard();
        test_back_pressure();
        test_rnone();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
